// File: rtl/divisor_pkg.sv
// rtl/divisor_pkg.sv - shared stage type and latency helper for the pipelined divider
package divisor_pkg;

  // Per-stage control bits; the width-dependent operands travel beside them as plain vectors.
  typedef struct packed {
    logic valid;
    logic den_zero;
    logic sign_q;
    logic sign_r;
  } etapa_t;

  function automatic int latencia(input int w);
    return w + 2;
  endfunction

endpackage

// File: rtl/divisor_etapa.sv
// rtl/divisor_etapa.sv - one registered restoring-division step (one quotient bit, MSB first)
module divisor_etapa
  import divisor_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  etapa_t       ctl_i,
  input  logic [W-1:0] den_i,
  input  logic [W:0]   rem_i,
  input  logic [W-1:0] quo_i,
  output etapa_t       ctl_o,
  output logic [W-1:0] den_o,
  output logic [W:0]   rem_o,
  output logic [W-1:0] quo_o
);

  etapa_t       ctl_d, ctl_q;
  logic [W-1:0] den_d, den_q;
  logic [W:0]   rem_d, rem_q;
  logic [W-1:0] quo_d, quo_q;
  logic [W+1:0] shifted;
  logic [W+1:0] trial;

  // quo carries the unconsumed dividend bits at the top and collects quotient bits at the bottom.
  always_comb begin
    shifted = {rem_i, quo_i[W-1]};
    trial   = shifted - {2'b00, den_i};
    ctl_d   = ctl_i;
    den_d   = den_i;
    rem_d   = trial[W+1] ? shifted[W:0] : trial[W:0];
    quo_d   = {quo_i[W-2:0], ~trial[W+1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctl_q <= '0;
      den_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
    end else begin
      ctl_q <= ctl_d;
      den_q <= den_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  assign ctl_o = ctl_q;
  assign den_o = den_q;
  assign rem_o = rem_q;
  assign quo_o = quo_q;

endmodule

// File: rtl/divisor_segmentado.sv
// rtl/divisor_segmentado.sv - pipelined divider, one op per clock; DIVISOR_SIGNED_EN selects signed mode
module divisor_segmentado
  import divisor_pkg::*;
#(
  parameter int tamanyo = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [tamanyo-1:0] num,
  input  logic [tamanyo-1:0] den,
  output logic [tamanyo-1:0] coc,
  output logic [tamanyo-1:0] res,
  output logic               done
);

  localparam int W = tamanyo;

  etapa_t       ctl_c [0:W];
  logic [W-1:0] den_c [0:W];
  logic [W:0]   rem_c [0:W];
  logic [W-1:0] quo_c [0:W];

  etapa_t       ent_ctl_d, ent_ctl_q;
  logic [W-1:0] ent_den_d, ent_den_q;
  logic [W-1:0] ent_quo_d, ent_quo_q;

  always_comb begin
    ent_ctl_d.valid    = start;
    ent_ctl_d.den_zero = (den == '0);
`ifdef DIVISOR_SIGNED_EN
    ent_ctl_d.sign_r   = num[W-1];
    ent_ctl_d.sign_q   = num[W-1] ^ den[W-1];
    ent_quo_d          = num[W-1] ? -num : num;
    ent_den_d          = den[W-1] ? -den : den;
`else
    ent_ctl_d.sign_r   = 1'b0;
    ent_ctl_d.sign_q   = 1'b0;
    ent_quo_d          = num;
    ent_den_d          = den;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent_ctl_q <= '0;
      ent_den_q <= '0;
      ent_quo_q <= '0;
    end else begin
      ent_ctl_q <= ent_ctl_d;
      ent_den_q <= ent_den_d;
      ent_quo_q <= ent_quo_d;
    end
  end

  assign ctl_c[0] = ent_ctl_q;
  assign den_c[0] = ent_den_q;
  assign rem_c[0] = '0;
  assign quo_c[0] = ent_quo_q;

  for (genvar k = 0; k < W; k++) begin : g_etapa
    divisor_etapa #(.W(W)) u_etapa (
      .clk   (clk),
      .rst_n (rst_n),
      .ctl_i (ctl_c[k]),
      .den_i (den_c[k]),
      .rem_i (rem_c[k]),
      .quo_i (quo_c[k]),
      .ctl_o (ctl_c[k+1]),
      .den_o (den_c[k+1]),
      .rem_o (rem_c[k+1]),
      .quo_o (quo_c[k+1])
    );
  end

  logic         fin_valid_d, fin_valid_q;
  logic [W-1:0] fin_coc_d, fin_coc_q;
  logic [W-1:0] fin_res_d, fin_res_q;
  logic [W-1:0] coc_d, coc_q;
  logic [W-1:0] res_d, res_q;
  logic         done_d, done_q;

  // A zero divisor leaves rem = |num|, so sign correction alone restores res = num.
  always_comb begin
    fin_valid_d = ctl_c[W].valid;
`ifdef DIVISOR_SIGNED_EN
    fin_coc_d   = ctl_c[W].sign_q ? -quo_c[W] : quo_c[W];
    fin_res_d   = ctl_c[W].sign_r ? -rem_c[W][W-1:0] : rem_c[W][W-1:0];
`else
    fin_coc_d   = quo_c[W];
    fin_res_d   = rem_c[W][W-1:0];
`endif
    if (ctl_c[W].den_zero) begin
      fin_coc_d = '1;
    end
    coc_d  = fin_valid_q ? fin_coc_q : coc_q;
    res_d  = fin_valid_q ? fin_res_q : res_q;
    done_d = fin_valid_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fin_valid_q <= 1'b0;
      fin_coc_q   <= '0;
      fin_res_q   <= '0;
      coc_q       <= '0;
      res_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      fin_valid_q <= fin_valid_d;
      fin_coc_q   <= fin_coc_d;
      fin_res_q   <= fin_res_d;
      coc_q       <= coc_d;
      res_q       <= res_d;
      done_q      <= done_d;
    end
  end

  assign coc  = coc_q;
  assign res  = res_q;
  assign done = done_q;

endmodule

// File: tb/tb_divisor_segmentado.sv
// tb/tb_divisor_segmentado.sv - self-checking bench: vector table, corner sequences, random ops vs model
module tb_divisor_segmentado;
  import divisor_pkg::*;

  localparam int W   = 8;
  localparam int LAT = latencia(W);

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] num;
  logic [W-1:0] den;
  logic [W-1:0] coc;
  logic [W-1:0] res;
  logic         done;

  divisor_segmentado #(.tamanyo(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .num   (num),
    .den   (den),
    .coc   (coc),
    .res   (res),
    .done  (done)
  );

  typedef struct {
    logic [7:0] n;
    logic [7:0] d;
    logic [7:0] q;
    logic [7:0] r;
    int         t;
  } exp_t;

  typedef struct {
    logic [7:0] n;
    logic [7:0] d;
    logic [7:0] q_s;
    logic [7:0] r_s;
    logic [7:0] q_u;
    logic [7:0] r_u;
  } vec_t;

  int         checks;
  int         failures;
  int         edge_cnt;
  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] last_coc;
  logic [7:0] last_res;
  vec_t       tbl [12];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic void ref_div(input logic [7:0] n, input logic [7:0] d,
                                  output logic [7:0] q, output logic [7:0] r);
    int sn, sd, qi, ri;
    if (d == 8'd0) begin
      q = 8'hFF;
      r = n;
    end else begin
`ifdef DIVISOR_SIGNED_EN
      sn = int'($signed(n));
      sd = int'($signed(d));
`else
      sn = int'(n);
      sd = int'(d);
`endif
      qi = sn / sd;
      ri = sn % sd;
      q  = qi[7:0];
      r  = ri[7:0];
    end
  endfunction

  // Called on a falling edge; the operation is sampled on the following rising edge.
  task automatic issue(input logic [7:0] n, input logic [7:0] d, input logic [7:0] q, input logic [7:0] r);
    exp_t e;
    e.n = n; e.d = d; e.q = q; e.r = r; e.t = edge_cnt + 1;
    start = 1'b1;
    num   = n;
    den   = d;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue_model(input logic [7:0] n, input logic [7:0] d);
    logic [7:0] q, r;
    ref_div(n, d, q, r);
    issue(n, d, q, r);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4 * LAT) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  // Scoreboard: every done must match the oldest outstanding op at exactly LAT edges.
  always begin
    @(posedge clk);
    #2;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", {31'b0, done}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("coc", coc, mon_e.q);
        chk("res", res, mon_e.r);
        chk("latency", edge_cnt - mon_e.t, LAT);
        last_coc = mon_e.q;
        last_res = mon_e.r;
      end
    end else begin
      chk("hold_coc", coc, last_coc);
      chk("hold_res", res, last_res);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] n, d;
    checks   = 0;
    failures = 0;
    edge_cnt = 0;
    last_coc = 8'h00;
    last_res = 8'h00;
    rst_n    = 1'b0;
    start    = 1'b0;
    num      = '0;
    den      = '0;

    tbl[0]  = '{8'd100, 8'd7,  8'h0E, 8'h02, 8'h0E, 8'h02};
    tbl[1]  = '{8'h9C,  8'd7,  8'hF2, 8'hFE, 8'h16, 8'h02};
    tbl[2]  = '{8'd100, 8'hF9, 8'hF2, 8'h02, 8'h00, 8'h64};
    tbl[3]  = '{8'h9C,  8'hF9, 8'h0E, 8'hFE, 8'h00, 8'h9C};
    tbl[4]  = '{8'd50,  8'd0,  8'hFF, 8'h32, 8'hFF, 8'h32};
    tbl[5]  = '{8'h80,  8'hFF, 8'h80, 8'h00, 8'h00, 8'h80};
    tbl[6]  = '{8'd0,   8'd5,  8'h00, 8'h00, 8'h00, 8'h00};
    tbl[7]  = '{8'd7,   8'd9,  8'h00, 8'h07, 8'h00, 8'h07};
    tbl[8]  = '{8'h80,  8'd0,  8'hFF, 8'h80, 8'hFF, 8'h80};
    tbl[9]  = '{8'hFF,  8'd2,  8'h00, 8'hFF, 8'h7F, 8'h01};
    tbl[10] = '{8'hF9,  8'd2,  8'hFD, 8'hFF, 8'h7C, 8'h01};
    tbl[11] = '{8'h7F,  8'h7F, 8'h01, 8'h00, 8'h01, 8'h00};

    repeat (2) @(negedge clk);
    chk("reset_coc", coc, 0);
    chk("reset_res", res, 0);
    chk("reset_done", {31'b0, done}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
`ifdef DIVISOR_SIGNED_EN
      issue(tbl[i].n, tbl[i].d, tbl[i].q_s, tbl[i].r_s);
`else
      issue(tbl[i].n, tbl[i].d, tbl[i].q_u, tbl[i].r_u);
`endif
      drain();
    end

    // 12 back-to-back issues must come out as 12 consecutive, in-order results.
    for (int i = 0; i < 12; i++) begin
      issue_model(8'($urandom), 8'($urandom));
    end
    drain();

    // Reset mid-flight: three ops discarded, start during reset ignored, first op after release kept.
    issue_model(8'd100, 8'd7);
    issue_model(8'h9C, 8'd3);
    issue_model(8'd77, 8'd11);
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    num   = 8'd33;
    den   = 8'd3;
    exp_q.delete();
    last_coc = 8'h00;
    last_res = 8'h00;
    @(negedge clk);
    chk("midreset_coc", coc, 0);
    chk("midreset_res", res, 0);
    chk("midreset_done", {31'b0, done}, 0);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    issue_model(8'd45, 8'd6);
    drain();
    repeat (2 * LAT) @(negedge clk);

    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        n = 8'($urandom);
        d = 8'($urandom);
        case ($urandom_range(0, 15))
          0: d = 8'h00;
          1: begin n = 8'h80; d = 8'hFF; end
          2: d = 8'h01;
          3: n = 8'h00;
          default: ;
        endcase
        issue_model(n, d);
      end else begin
        @(negedge clk);
      end
    end
    drain();
    repeat (2 * LAT) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
